// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the packet-aware FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_DATA_W  = 8;

  // Increment a round-robin pointer modulo n; works for non-power-of-two n.
  function automatic int next_ptr(input int ptr, input int n);
    if (ptr + 1 >= n) begin
      return 0;
    end
    return ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority find-first: returns the first set request at or after ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Walk the candidates from farthest to nearest so the nearest set bit wins.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand     = (int'(ptr) + k) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers. A winner keeps the port until its last beat is taken.
// Optional per-requester saturating beat counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]  beat_cnt
`endif
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W-1:0]   winner;
  logic              has_winner;
  logic              accept;
  logic [DATA_W-1:0] req_data_arr [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Unpack the flat data bus so the winner's beat can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Pick the winner (owner when locked, else round-robin) and decide acceptance;
  // everything is forced quiet while reset is held.
  always_comb begin
    winner     = rr_ptr_q;
    has_winner = 1'b0;
    if (state_q == LOCKED) begin
      winner     = owner_q;
      has_winner = 1'b1;
    end else if (pick_found) begin
      winner     = pick_idx;
      has_winner = 1'b1;
    end
    accept = rst_n & has_winner & req_valid[winner] & ~fifo_full;
  end

  // Drive the FIFO and handshake outputs from the accept decision.
  always_comb begin
    req_ready         = '0;
    req_ready[winner] = accept;
    fifo_wr_en        = accept;
    fifo_wr_data      = accept ? req_data_arr[winner] : '0;
    grant_valid       = rst_n & has_winner;
    grant_id          = rst_n ? winner : '0;
  end

  // Next-state: a last beat releases the port and advances the pointer past the
  // winner; a non-last beat in IDLE locks the port to the winner.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (accept) begin
      if (req_last[winner]) begin
        state_d  = IDLE;
        rr_ptr_d = ID_W'(next_ptr(int'(winner), NUM_REQ));
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        owner_d = winner;
      end
    end
  end

  // Arbitration state registers; reset abandons any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [CNT_W-1:0] beat_cnt_q [NUM_REQ];
  logic [CNT_W-1:0] beat_cnt_d [NUM_REQ];

  // Saturating per-requester accepted-beat counters.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_cnt_d[i] = beat_cnt_q[i];
      if (req_ready[i] && (beat_cnt_q[i] != '1)) begin
        beat_cnt_d[i] = beat_cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        beat_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        beat_cnt_q[i] <= beat_cnt_d[i];
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_cnt[i*CNT_W +: CNT_W] = beat_cnt_q[i];
    end
  end
`endif

endmodule
